booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//   Sequential radix-4 Booth multiplier, parametrised in operand width and signedness.
//   Recodes multiplier mr two bits per cycle into digits {-2,-1,0,+1,+2} and accumulates
//   digit*md into a shift accumulator. Next generation of the combinational booth encoder:
//   adds width/mode parameters, iteration control and a start/busy/done handshake.
//   Sits between operand registers and the datapath result bus.
// PARAMETERS
//   WIDTH   8  operand width in bits; must be even and >= 4
//   SIGNED  1  1 = two's-complement operands; 0 = unsigned operands
// PORTS
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous active-low reset
//   start    in   1          request; sampled only while busy==0
//   mr       in   WIDTH      multiplier (Booth-recoded operand)
//   md       in   WIDTH      multiplicand
//   busy     out  1          iteration in progress
//   done     out  1          one-cycle pulse: product valid
//   product  out  2*WIDTH    result; held until the next accepted start
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; busy=0, done=0, product=0; accumulator,
//     counter and operand registers cleared. Reset mid-RUN aborts; no done pulse is produced.
//   - N = WIDTH/2 iterations if SIGNED=1; WIDTH/2+1 if SIGNED=0.
//   - Operand extension: operands extend to WIDTH+2 bits (sign-extend if SIGNED, else zero-extend).
//   - FSM IDLE -> RUN -> DONE -> IDLE:
//     IDLE: busy=0. start=1 at edge E0 -> latch M=ext(md), Q=ext(mr), q_-1=0,
//           A=0, cnt=0 -> RUN.
//     RUN:  busy=1. At each edge E1..EN:
//           - form digit d from {Q[1],Q[0],q_-1}:
//             000,111 -> 0; 001,010 -> +M; 011 -> +2M; 100 -> -2M; 101,110 -> -M.
//           - A += d, computed at WIDTH+3 bits so that +/-2M cannot overflow.
//           - {A,Q,q_-1} arithmetic-shift right by 2; cnt++.
//           - At EN, write product = low 2*WIDTH bits of {A,Q} -> DONE.
//     DONE: busy=0, done=1 for exactly one cycle -> IDLE at next edge.
//           start=1 during DONE is accepted (counts as E0 of the next operation)
//           -> back-to-back throughput is one result per N+1 cycles.
//   - Latency: done is high in the cycle after edge E(N).
//     WIDTH=8: 4 cycles after the accept edge if SIGNED=1; 5 if SIGNED=0.
//   - start while busy=1 is ignored. mr/md changes after E0 have no effect.
//   - product changes only at EN. It must not glitch or partially update during RUN.
//   - Arithmetic is exact modulo 2^(2*WIDTH). Signed corner -2^(W-1) * -2^(W-1) = 2^(2W-2) is exact.
//   - done and busy are never high together.
// TESTING
//   1 WIDTH=8,SIGNED=1: mr=7, md=-3 (0xFD), start 1 cycle -> busy 4 cycles,
//     then done pulse with product=0xFFEB.
//   2 WIDTH=8,SIGNED=1: mr=md=0x80 -> product=0x4000.
//     Also mr=0x7F, md=0x80 -> product=0xC080.
//   3 WIDTH=8,SIGNED=0: mr=md=0xFF -> busy 5 cycles, product=0xFE01.
//     Also mr=0, md=0xAB -> product=0x0000.
//   4 Handshake: start held high continuously with changing operands.
//     -> operations accepted every 5 cycles (SIGNED=1); start during RUN ignored.
//     -> each product matches operands at its accept edge. Assert busy&done never both high.
//   5 Reset: rst_n low for 1 cycle mid-RUN (after E2), asynchronously to clk.
//     -> busy/done/product=0 immediately, no done pulse.
//     -> next start completes with correct result.
//   6 Random: 10k random mr/md for WIDTH in {4,8,16}, both SIGNED modes.
//     -> product == reference multiply; done exactly N edges after each accept.

Source files
------------

// File: rtl/booth_mult_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential Booth multiplier.
interface booth_mult_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     mr;
  logic [WIDTH-1:0]     md;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, mr, md, input busy, done, product);
  modport slave  (input start, mr, md, output busy, done, product);
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: recodes two multiplier bits per cycle into a digit in
// {-2,-1,0,+1,+2} and accumulates digit*md into a right-shifting {A,Q} register pair.
module booth_mult_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  booth_mult_seq_if.slave bus
);

  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned AW   = WIDTH + 3;
  localparam int unsigned SW   = AW + EW + 1;
  localparam int unsigned N    = SIGNED ? WIDTH / 2 : WIDTH / 2 + 1;
  localparam int unsigned CW   = $clog2(N + 1);
  // After N double-shifts the product's LSB sits this far above bit 0 of {A,Q}.
  localparam int unsigned BASE = EW - 2 * N;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [EW-1:0]        r_m;
  logic [EW-1:0]        r_q;
  logic                 r_qm1;
  logic [AW-1:0]        r_a;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_busy;
  logic                 w_done;
  logic [EW-1:0]        w_mr_ext;
  logic [EW-1:0]        w_md_ext;
  logic [AW-1:0]        w_m_a;
  logic [AW-1:0]        w_addend;
  logic [AW-1:0]        w_sum;
  logic [SW-1:0]        w_shifted;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_mr_ext = {{2{SIGNED & bus.mr[WIDTH-1]}}, bus.mr};
  assign w_md_ext = {{2{SIGNED & bus.md[WIDTH-1]}}, bus.md};
  assign w_accept = bus.start && (r_state != StRun);
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_m_a    = {r_m[EW-1], r_m};

  always_comb begin
    w_addend = '0;
    case ({r_q[1:0], r_qm1})
      3'b001, 3'b010: w_addend = w_m_a;
      3'b011:         w_addend = w_m_a << 1;
      3'b100:         w_addend = -(w_m_a << 1);
      3'b101, 3'b110: w_addend = -w_m_a;
      default:        w_addend = '0;
    endcase
  end

  assign w_sum     = r_a + w_addend;
  assign w_shifted = SW'($signed({w_sum, r_q, r_qm1}) >>> 2);
  assign w_prod    = w_shifted[BASE+1 +: 2*WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (bus.start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = bus.start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_busy = (r_state == StRun);
    w_done = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_a       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_m   <= w_md_ext;
      r_q   <= w_mr_ext;
      r_qm1 <= 1'b0;
      r_a   <= '0;
      r_cnt <= '0;
    end else if (r_state == StRun) begin
      {r_a, r_q, r_qm1} <= w_shifted;
      r_cnt             <= r_cnt + 1'b1;
      if (w_last) r_product <= w_prod;
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench: six multiplier configurations share stimulus; each has a cycle model and
// result scoreboard, plus directed scenario tasks on the 8-bit instances.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mr16 = '0;
  logic [15:0] md16 = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input int unsigned w, input bit s,
                                          input logic [15:0] a, input logic [15:0] b);
    longint x, y, mask, p;
    mask = (longint'(1) << w) - 1;
    x = longint'(a) & mask;
    y = longint'(b) & mask;
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int unsigned W = (g < 2) ? 4 : (g < 4) ? 8 : 16;
    localparam bit          S = ((g % 2) == 0);
    localparam int unsigned N = S ? W / 2 : W / 2 + 1;

    booth_mult_seq_if #(.WIDTH(W)) bus ();
    assign bus.start = start;
    assign bus.mr    = mr16[W-1:0];
    assign bus.md    = md16[W-1:0];

    booth_mult_seq #(.WIDTH(W), .SIGNED(S)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    logic [31:0] exp_q[$];
    int unsigned m_run = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_prod = '0;

    // Reference model: accept when not running, finish exactly N edges later.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_run  <= 0;
        m_done <= 1'b0;
        m_prod <= '0;
        exp_q.delete();
      end else if (m_run != 0) begin
        m_run  <= m_run - 1;
        m_done <= (m_run == 1);
        if (m_run == 1 && exp_q.size() != 0) m_prod <= exp_q.pop_front();
      end else begin
        m_done <= 1'b0;
        if (start) begin
          m_run <= N;
          exp_q.push_back(ref_mul(W, S, mr16, md16));
        end
      end
    end

    always @(negedge clk) begin
      n_checks++;
      if (bus.busy !== (m_run != 0))
        $display("FAIL dut%0d busy: got %b want %b", g, bus.busy, (m_run != 0));
      else n_pass++;
      n_checks++;
      if (bus.done !== m_done)
        $display("FAIL dut%0d done: got %b want %b", g, bus.done, m_done);
      else n_pass++;
      n_checks++;
      if (32'(bus.product) !== m_prod)
        $display("FAIL dut%0d product: got %h want %h", g, bus.product, m_prod);
      else n_pass++;
      n_checks++;
      if ((bus.busy && bus.done) !== 1'b0)
        $display("FAIL dut%0d busy_and_done: got 1 want 0", g);
      else n_pass++;
    end
  end

  function automatic logic sel_busy(input int sel);
    return (sel == 2) ? g_dut[2].bus.busy : g_dut[3].bus.busy;
  endfunction

  function automatic logic sel_done(input int sel);
    return (sel == 2) ? g_dut[2].bus.done : g_dut[3].bus.done;
  endfunction

  function automatic logic [31:0] sel_prod(input int sel);
    return (sel == 2) ? 32'(g_dut[2].bus.product) : 32'(g_dut[3].bus.product);
  endfunction

  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] prod, output int busy_cycles, output bit ok);
    @(posedge clk); #1;
    mr16 = a; md16 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mr16 = 16'hDEAD; md16 = 16'hBEEF;
    busy_cycles = 0; ok = 1'b0; prod = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel_busy(sel)) busy_cycles++;
      if (sel_done(sel)) begin
        ok = 1'b1;
        prod = sel_prod(sel);
        break;
      end
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic check_op(input string name, input int sel, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] want, input int want_busy);
    logic [31:0] prod;
    int          bc;
    bit          ok;
    run_op(sel, a, b, prod, bc, ok);
    n_checks++;
    if (!ok) $display("FAIL %s timeout: got no done want done", name);
    else n_pass++;
    n_checks++;
    if (prod !== want) $display("FAIL %s product: got %h want %h", name, prod, want);
    else n_pass++;
    if (want_busy > 0) begin
      n_checks++;
      if (bc != want_busy) $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, want_busy);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({g_dut[2].bus.busy, g_dut[2].bus.done, g_dut[2].bus.product} !== 18'h0)
      $display("FAIL reset_state: got %b/%b/%h want 0/0/0000", g_dut[2].bus.busy,
               g_dut[2].bus.done, g_dut[2].bus.product);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_signed();
    check_op("s8_7x-3", 2, 16'h0007, 16'hFFFD, 32'h0000FFEB, 4);
    check_op("s8_min_sq", 2, 16'h0080, 16'h0080, 32'h00004000, 4);
    check_op("s8_7f_x80", 2, 16'h007F, 16'h0080, 32'h0000C080, 4);
  endtask

  task automatic test_unsigned();
    check_op("u8_ff_sq", 3, 16'h00FF, 16'h00FF, 32'h0000FE01, 5);
    check_op("u8_zero", 3, 16'h0000, 16'h00AB, 32'h00000000, 5);
  endtask

  task automatic test_back_to_back();
    int dt[$];
    @(posedge clk); #1;
    start = 1'b1;
    mr16 = 16'($urandom); md16 = 16'($urandom);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (g_dut[2].bus.done) dt.push_back(i);
      @(posedge clk); #1;
      mr16 = 16'($urandom); md16 = 16'($urandom);
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    n_checks++;
    if (dt.size() < 6) $display("FAIL b2b_count: got %0d want >=6", dt.size());
    else n_pass++;
    for (int k = 1; k < dt.size(); k++) begin
      n_checks++;
      if (dt[k] - dt[k-1] != 5)
        $display("FAIL b2b_spacing: got %0d want 5", dt[k] - dt[k-1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    @(posedge clk); #1;
    mr16 = 16'h0019; md16 = 16'hFFF3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({g_dut[2].bus.busy, g_dut[2].bus.done, g_dut[2].bus.product} !== 18'h0)
      $display("FAIL midrun_reset: got %b/%b/%h want 0/0/0000", g_dut[2].bus.busy,
               g_dut[2].bus.done, g_dut[2].bus.product);
    else n_pass++;
    #10 rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (g_dut[2].bus.done) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL midrun_no_done: got %0d want 0", dones);
    else n_pass++;
    check_op("post_reset", 2, 16'hFFFB, 16'h0009, 32'h0000FFD3, 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) != 0);
      mr16 = 16'($urandom);
      md16 = 16'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
